// File: rtl/led_pkg.sv
// Shared constants and types for the LED frame builder and its channel scaler.
package led_pkg;

  localparam int NUM_LEDS = 8;
  localparam int LED_W    = 24;
  localparam int CH_W     = 8;
  localparam int IDX_W    = $clog2(NUM_LEDS);

  // GRB word layout: G[23:16] R[15:8] B[7:0]
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  typedef logic [LED_W-1:0] color_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCALE,
    S_UPDATE
  } state_e;

endpackage

// File: rtl/led_scale.sv
// Combinational GRB colour scaler: every channel becomes (c * (brightness + 1)) >> 8,
// so brightness 255 is identity and 0 is black.
module led_scale
  import led_pkg::*;
(
  input  color_t          color_i,
  input  logic [CH_W-1:0] bright_i,
  output color_t          color_o
);

  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                input logic [CH_W-1:0] b);
    logic [2*CH_W-1:0] p;
    p = {{CH_W{1'b0}}, c} * ({{CH_W{1'b0}}, b} + (2*CH_W)'(1));
    return CH_W'(p >> CH_W);
  endfunction

  assign color_o[G_LSB +: CH_W] = scale_ch(color_i[G_LSB +: CH_W], bright_i);
  assign color_o[R_LSB +: CH_W] = scale_ch(color_i[R_LSB +: CH_W], bright_i);
  assign color_o[B_LSB +: CH_W] = scale_ch(color_i[B_LSB +: CH_W], bright_i);

endmodule

// File: rtl/led_frame_builder.sv
// Builds the eight GRB words for LED_controller: shadow bank + commit, brightness
// scaling and blink/chase animation, with all eight outputs swapped in one edge.
module led_frame_builder
  import led_pkg::*;
#(
  parameter logic [23:0] STEP_DIV = 24'd5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [LED_W-1:0] wr_data,
  input  logic             commit,
  input  logic [CH_W-1:0]  brightness,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led1,
  output logic [LED_W-1:0] led2,
  output logic [LED_W-1:0] led3,
  output logic [LED_W-1:0] led4,
  output logic [LED_W-1:0] led5,
  output logic [LED_W-1:0] led6,
  output logic [LED_W-1:0] led7,
  output logic [LED_W-1:0] led8,
  output logic             busy,
  output logic             update_done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  color_t           shadow_q [NUM_LEDS];
  color_t           shadow_d [NUM_LEDS];
  color_t           active_q [NUM_LEDS];
  color_t           staging_q [NUM_LEDS];
  color_t           led_q [NUM_LEDS];
  logic [23:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [IDX_W-1:0] chase_q, chase_d;
  logic [CH_W-1:0]  bright_q;
  mode_e            mode_q, mode_in;
  logic             pass_phase_q;
  logic [IDX_W-1:0] pass_chase_q;
  logic             pending_q, pending_d, pend_copy_q, pend_copy_d;
  logic             update_done_q;
  logic             anim_on, step_evt, trigger, load, copy, keep;
  color_t           scaled;

  assign mode_in = mode_e'(mode);

  // Write bypass: a commit in the same cycle as a write copies the written value.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
  end

  assign anim_on  = (mode_in == MODE_BLINK) || (mode_in == MODE_CHASE);
  assign step_evt = anim_on && (cnt_q == STEP_DIV - 24'd1);
  assign trigger  = commit || step_evt;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    cnt_d   = (anim_on && !step_evt) ? cnt_q + 24'd1 : '0;
    phase_d = phase_q;
    chase_d = chase_q;
    case (mode_in)
      MODE_BLINK: phase_d = phase_q ^ step_evt;
      MODE_CHASE: chase_d = chase_q + IDX_W'(step_evt);
      default:    phase_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    pend_copy_d = pend_copy_q;
    load        = 1'b0;
    copy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        load = trigger;
        copy = commit;
      end
      S_SCALE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_LEDS - 1)) state_d = S_UPDATE;
        // Triggers during a pass merge into a single follow-up pass.
        if (trigger) begin
          pending_d   = 1'b1;
          pend_copy_d = pend_copy_q | commit;
        end
      end
      S_UPDATE: begin
        state_d     = S_IDLE;
        load        = pending_q || trigger;
        copy        = pend_copy_q || commit;
        pending_d   = 1'b0;
        pend_copy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_SCALE;
      idx_d   = '0;
    end
  end

  always_comb begin
    keep = 1'b1;
    if (mode_q == MODE_BLINK)      keep = pass_phase_q;
    else if (mode_q == MODE_CHASE) keep = (idx_q == pass_chase_q);
  end

  led_scale u_scale (
    .color_i  (active_q[idx_q]),
    .bright_i (bright_q),
    .color_o  (scaled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      phase_q       <= 1'b1;
      chase_q       <= '0;
      bright_q      <= '0;
      mode_q        <= MODE_STATIC;
      pass_phase_q  <= 1'b1;
      pass_chase_q  <= '0;
      pending_q     <= 1'b0;
      pend_copy_q   <= 1'b0;
      update_done_q <= 1'b0;
      // NOTE: the colour banks are reset too: a reset must blank the frame, and staging is
      // cleared so nothing undefined can ever reach the outputs.
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      staging_q     <= '{default: '0};
      led_q         <= '{default: '0};
    end else begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      chase_q       <= chase_d;
      pending_q     <= pending_d;
      pend_copy_q   <= pend_copy_d;
      shadow_q      <= shadow_d;
      update_done_q <= (state_q == S_UPDATE);
      if (load) begin
        bright_q     <= brightness;
        mode_q       <= mode_in;
        pass_phase_q <= phase_d;
        pass_chase_q <= chase_d;
      end
      if (copy) active_q <= shadow_d;
      if (state_q == S_SCALE) staging_q[idx_q] <= keep ? scaled : '0;
      if (state_q == S_UPDATE) led_q <= staging_q;
    end
  end

  assign led1        = led_q[0];
  assign led2        = led_q[1];
  assign led3        = led_q[2];
  assign led4        = led_q[3];
  assign led5        = led_q[4];
  assign led6        = led_q[5];
  assign led7        = led_q[6];
  assign led8        = led_q[7];
  assign busy        = (state_q != S_IDLE);
  assign update_done = update_done_q;

endmodule

// File: tb/tb_led_frame_builder.sv
// Self-checking bench for led_frame_builder: directed steps with randomized colours,
// checked against a frame-level reference model.
module tb_led_frame_builder;

  localparam logic [23:0] STEP = 24'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        commit = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [7:0]  brightness = '0;
  logic [1:0]  mode = '0;
  logic [23:0] led [8];
  logic        busy, update_done;

  int checks = 0;
  int failures = 0;

  logic [23:0] sh  [8];
  logic [23:0] act [8];

  led_frame_builder #(.STEP_DIV(STEP)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .brightness  (brightness),
    .mode        (mode),
    .led1        (led[0]),
    .led2        (led[1]),
    .led3        (led[2]),
    .led4        (led[3]),
    .led5        (led[4]),
    .led6        (led[5]),
    .led7        (led[6]),
    .led8        (led[7]),
    .busy        (busy),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale_ref(input logic [23:0] c, input int br);
    logic [23:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      r[ch*8 +: 8] = 8'((int'(c[ch*8 +: 8]) * (br + 1)) / 256);
    return r;
  endfunction

  task automatic check_frame(input string tag, input int m, input bit ph, input int ch,
                             input int br);
    for (int i = 0; i < 8; i++) begin
      logic [23:0] e;
      e = scale_ref(act[i], br);
      if (m == 1 && !ph) e = '0;
      if (m == 2 && i != ch) e = '0;
      check($sformatf("%s_led%0d", tag, i + 1), 32'(led[i]), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_led(input int a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    sh[a]   = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    act    = sh;
    step();
    commit = 1'b0;
  endtask

  // Cycles until update_done is seen (bounded), plus cycles with busy high along the way.
  task automatic wait_pulse(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    do begin
      step();
      n++;
      if (busy) nb++;
    end while (!update_done && n < 64);
  endtask

  task automatic count_pulses(input int cycles, output int hits);
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (update_done) hits++;
    end
  endtask

  initial begin
    int n, nb, hits, chase, nz;
    bit phase;
    logic [23:0] v;

    for (int i = 0; i < 8; i++) begin
      sh[i]  = '0;
      act[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(update_done), 32'(0));
    check_frame("rst", 0, 1'b1, 0, 255);

    // Single white LED, latency and busy length
    brightness = 8'd255;
    mode       = 2'd0;
    write_led(0, 24'hFFFFFF);
    pulse_commit();
    wait_pulse(n, nb);
    check("lat_first", n, 9);
    check("busy_cycles", nb, 9);
    check("white_led1", 32'(led[0]), 32'h00FFFFFF);
    check_frame("white", 0, 1'b1, 0, 255);
    step();
    check("done_width", 32'(update_done), 32'(0));

    // Shadow write and brightness change alone must not touch outputs
    brightness = 8'd10;
    write_led(0, 24'h000000);
    count_pulses(12, hits);
    check("no_trig_pulses", hits, 0);
    check("no_trig_led1", 32'(led[0]), 32'h00FFFFFF);

    // Directed scaling
    write_led(2, 24'h804020);
    brightness = 8'd127;
    pulse_commit();
    wait_pulse(n, nb);
    check("half_led3", 32'(led[2]), 32'h00402010);
    check_frame("half", 0, 1'b1, 0, 127);
    brightness = 8'd0;
    pulse_commit();
    wait_pulse(n, nb);
    check("zero_led3", 32'(led[2]), 32'(0));

    // Random frames, static and reserved mode, last write bypassed into the commit
    for (int t = 0; t < 4; t++) begin
      int br, m;
      for (int i = 0; i < 7; i++) write_led(i, 24'($urandom()));
      br         = int'($urandom_range(0, 255));
      m          = ($urandom_range(0, 1) == 1) ? 3 : 0;
      brightness = 8'(br);
      mode       = 2'(m);
      v          = 24'($urandom());
      wr_en      = 1'b1;
      wr_addr    = 3'd7;
      wr_data    = v;
      sh[7]      = v;
      pulse_commit();
      wr_en      = 1'b0;
      wait_pulse(n, nb);
      check($sformatf("rnd%0d_lat", t), n, 9);
      check_frame($sformatf("rnd%0d", t), m, 1'b1, 0, br);
    end

    // Blink
    mode       = 2'd0;
    brightness = 8'd255;
    write_led(0, 24'h0000FF);
    for (int i = 1; i < 8; i++) write_led(i, 24'h000000);
    mode = 2'd1;
    pulse_commit();
    wait_pulse(n, nb);
    phase = 1'b1;
    check("blink_commit_lat", n, 9);
    check_frame("blink_c", 1, phase, 0, 255);
    for (int p = 0; p < 5; p++) begin
      wait_pulse(n, nb);
      phase = ~phase;
      if (p > 0) check($sformatf("blink%0d_period", p), n, 16);
      check_frame($sformatf("blink%0d", p), 1, phase, 0, 255);
    end

    // Chase
    mode = 2'd0;
    for (int i = 0; i < 8; i++) write_led(i, 24'h00FF00);
    mode = 2'd2;
    pulse_commit();
    wait_pulse(n, nb);
    chase = 0;
    check_frame("chase_c", 2, 1'b1, chase, 255);
    for (int s = 0; s < 9; s++) begin
      wait_pulse(n, nb);
      chase = (chase + 1) % 8;
      check_frame($sformatf("chase%0d", s), 2, 1'b1, chase, 255);
      nz = 0;
      for (int i = 0; i < 8; i++) if (led[i] != 24'h0) nz++;
      check($sformatf("chase%0d_one_lit", s), nz, 1);
    end

    // Commit while busy, with a shadow write in between
    mode = 2'd0;
    step();
    for (int i = 0; i < 8; i++) write_led(i, 24'($urandom()) | 24'h010101);
    pulse_commit();
    write_led(5, ~sh[5]);
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_pulse(n, nb);
    check("pend_first_lat", n, 6);
    check_frame("pend_first", 0, 1'b1, 0, 255);
    act = sh;
    wait_pulse(n, nb);
    check("pend_gap", n, 9);
    check_frame("pend_second", 0, 1'b1, 0, 255);
    count_pulses(12, hits);
    check("pend_no_extra", hits, 0);

    // Reset in the middle of SCALE
    pulse_commit();
    repeat (3) step();
    reset = 1'b1;
    #2;
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_done", 32'(update_done), 32'(0));
    for (int i = 0; i < 8; i++) act[i] = '0;
    check_frame("rst_mid", 0, 1'b1, 0, 255);
    step();
    step();
    reset = 1'b0;
    count_pulses(30, hits);
    check("rst_no_pulse", hits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_builder.md
Name: led_frame_builder

Overview:
- Upstream feeder for LED_controller; produces the eight 24-bit GRB words led1..led8 that the controller serialises onto dat_out.
- Host writes per-LED colours into a shadow bank and commits them.
- Block applies global brightness scaling and optional blink/chase animation.
- Outputs update atomically, so the controller never streams a half-updated frame.

Parameters:
- NUM_LEDS, 8, LED count. Fixed at 8 to match controller ports.
- STEP_DIV, 24'd5000000, clocks per animation step (blink toggle / chase advance).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write shadow[wr_addr] this cycle
- wr_addr  in  3  LED index 0..7 (0 maps to led1)
- wr_data  in  24  GRB colour, G[23:16] R[15:8] B[7:0]
- commit  in  1  single-cycle request: copy shadow to active bank and render
- brightness  in  8  global scale, sampled at render start
- mode  in  2  0 static, 1 blink, 2 chase, 3 reserved (treated as static)
- led1..led8  out  24 each  rendered colours to LED_controller
- busy  out  1  render pass in progress
- update_done  out  1  one-cycle pulse when outputs change

Behaviour:
- Reset, asynchronous: led1..led8=0, shadow=0, active=0, busy=0, update_done=0, step counter=0, chase_idx=0, blink phase=on, pending=0, state IDLE.
- Shadow write: on wr_en, shadow[wr_addr]<=wr_data. Allowed at any time, including while busy. Never affects outputs until a commit.
- Commit with wr_en in the same cycle: the copy includes that write (bypass).
- Step counter (mode 1/2 only):
  - Counts 0..STEP_DIV-1 and wraps; the wrap cycle is a step event.
  - Mode 1: toggles phase.
  - Mode 2: chase_idx increments 7->0 wrap.
  - Mode 0/3: counter held at 0, phase=on, chase_idx held.
- Render trigger = commit OR step event.
- FSM IDLE -> SCALE -> UPDATE -> IDLE:
  - IDLE: on trigger at edge k, load active<=shadow (commit only), latch brightness, mode, phase, chase_idx; idx<=0; ->SCALE.
  - SCALE: edges k+1..k+8 compute staging[idx] for idx 0..7, one LED per cycle, one shared multiplier. At idx=7 ->UPDATE.
  - UPDATE, edge k+9: led1..led8<=staging simultaneously; update_done=1 for one cycle. If pending, clear it, reload as in IDLE and ->SCALE; else ->IDLE.
- busy = (state != IDLE). Latency from trigger edge to new outputs = 9 clocks.
- Scaling, per 8-bit channel: out = (c * (brightness+1)) >> 8. brightness=255 gives identity; brightness=0 gives 0. No rounding.
- Masking, applied after scaling:
  - Mode 1 with phase off: all LEDs 0.
  - Mode 2: only LED chase_idx keeps its colour; others 0.
- Triggers while busy set pending. Only one pending pass; further triggers merge. A commit while busy re-copies shadow when the pending pass starts.
- Mode or brightness change alone does not trigger a render; it takes effect on the next trigger.
- Reset mid-pass: aborts immediately; outputs go to 0.

Decomposition:
- Shared package led_pkg: NUM_LEDS, LED_W=24, channel slice constants (G/R/B), mode encodings (MODE_STATIC, MODE_BLINK, MODE_CHASE), FSM state typedef.
- One natural sub-module: led_scale, the combinational 24-bit colour x 8-bit brightness channel scaler, instanced once.

Test Plan:
- Reset, write LED0=24'hFFFFFF, brightness=255, mode 0, commit -> led1=24'hFFFFFF, others 0; update_done pulse exactly 9 clocks after commit edge; busy high 9 cycles.
- Write LED2=24'h804020, brightness=127, commit -> led3=24'h402010; brightness=0, commit -> led3=0.
- Mode 1, STEP_DIV=16, LED0=24'h0000FF committed -> led1 alternates 24'h0000FF / 0 with one update_done per 16 clocks.
- Mode 2, STEP_DIV=16, all LEDs 24'h00FF00 -> exactly one non-zero LED, index advancing 0..7 then wrapping to 0.
- Commit issued 3 cycles into a pass, with a shadow write in between -> two update_done pulses, 9 clocks apart; final outputs reflect the new write; no torn frame.
- Assert reset during SCALE -> outputs, busy and update_done go to 0 asynchronously; no pulse after release until the next commit.
